// File: rtl/pipe_ctrl_n_if.sv
// Pipeline-control bundle: stall requests and redirect sources in, stage
// holds, flushes, accepted redirect and watchdog status out.
interface pipe_ctrl_n_if #(
  parameter int NUM_STAGES = 6,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 8
) ();
  logic [NUM_STAGES-1:0] stallreq_i;
  logic                  branch_flag_i;
  logic [ADDR_W-1:0]     branch_addr_i;
  logic                  trap_flag_i;
  logic [ADDR_W-1:0]     trap_addr_i;
  logic                  fetch_ready_i;
  logic [NUM_STAGES-1:0] stalled_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic                  branch_flag_o;
  logic [ADDR_W-1:0]     branch_addr_o;
  logic                  redirect_pending_o;
  logic                  stall_timeout_o;
  logic [CNT_W-1:0]      stall_cycles_o;

  modport master (
    output stallreq_i, branch_flag_i, branch_addr_i, trap_flag_i, trap_addr_i, fetch_ready_i,
    input  stalled_o, flush_o, branch_flag_o, branch_addr_o, redirect_pending_o,
           stall_timeout_o, stall_cycles_o
  );

  modport slave (
    input  stallreq_i, branch_flag_i, branch_addr_i, trap_flag_i, trap_addr_i, fetch_ready_i,
    output stalled_o, flush_o, branch_flag_o, branch_addr_o, redirect_pending_o,
           stall_timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl_n.sv
// N-stage pipeline control: stall vector, redirect arbitration with a pending
// hold while fetch is busy, per-stage flushes and a stall-duration watchdog.
module pipe_ctrl_n #(
  parameter int                    NUM_STAGES = 6,
  parameter int                    ADDR_W     = 32,
  parameter int                    BR_STAGE   = 3,
  parameter int                    TRAP_STAGE = 4,
  parameter logic [NUM_STAGES-1:0] BR_MASK    = NUM_STAGES'(6'b001100),
  parameter int                    CNT_W      = 8,
  parameter int                    TIMEOUT    = 200
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_n_if.slave bus
);
  function automatic logic [NUM_STAGES-1:0] flush_upto(input int stg);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int i = 1; i < NUM_STAGES; i++) if (i < stg) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [NUM_STAGES-1:0] BR_FLUSH   = flush_upto(BR_STAGE);
  localparam logic [NUM_STAGES-1:0] TRAP_FLUSH = flush_upto(TRAP_STAGE);
  localparam logic [NUM_STAGES-1:0] IF_BUBBLE  = NUM_STAGES'(2);
  localparam logic [CNT_W-1:0]      CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]      TO_PRE     = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                pend_trap_q, pend_trap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic [NUM_STAGES-1:0] eff, stall_req;
  logic                  pending, presented, accept, win_trap;
  logic [ADDR_W-1:0]     win_addr;
  logic [NUM_STAGES-1:0] stalled, flush;
  logic                  bflag, pend_out;
  logic [ADDR_W-1:0]     baddr;

  // Stage i holds when it or any later stage asks to stall.
  assign eff = bus.stallreq_i & ~(BR_MASK & {NUM_STAGES{bus.branch_flag_i}});
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stall
    assign stall_req[i] = |eff[NUM_STAGES-1:i];
  end

  assign pending   = (state_q == PENDING);
  assign presented = bus.trap_flag_i | bus.branch_flag_i | pending;
  assign accept    = presented & bus.fetch_ready_i;
  assign win_trap  = bus.trap_flag_i | (~bus.branch_flag_i & pending & pend_trap_q);
  assign win_addr  = bus.trap_flag_i   ? bus.trap_addr_i   :
                     bus.branch_flag_i ? bus.branch_addr_i : pend_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
      pend_trap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_trap_q <= pend_trap_d;
    end
  end

  // A refused presentation (re)latches the winner, so newer flags overwrite.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_trap_d = pend_trap_q;
    case (state_q)
      IDLE: if (presented && !bus.fetch_ready_i) begin
        state_d     = PENDING;
        pend_addr_d = win_addr;
        pend_trap_d = win_trap;
      end
      PENDING: if (accept) begin
        state_d = IDLE;
      end else begin
        pend_addr_d = win_addr;
        pend_trap_d = win_trap;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stalled  = '0;
    flush    = '0;
    bflag    = 1'b0;
    baddr    = '0;
    pend_out = 1'b0;
    if (rst) begin
      stalled  = stall_req | {{(NUM_STAGES-1){1'b0}}, pending};
      if (accept)       flush = win_trap ? TRAP_FLUSH : BR_FLUSH;
      else if (pending) flush = IF_BUBBLE;
      bflag    = accept;
      baddr    = presented ? win_addr : '0;
      pend_out = pending;
    end
  end

  always_comb begin
    cnt_d     = '0;
    timeout_d = 1'b0;
    if (|stalled) begin
      cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      timeout_d = (cnt_q == TO_PRE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.stalled_o          = stalled;
  assign bus.flush_o            = flush;
  assign bus.branch_flag_o      = bflag;
  assign bus.branch_addr_o      = baddr;
  assign bus.redirect_pending_o = pend_out;
  assign bus.stall_timeout_o    = timeout_q;
  assign bus.stall_cycles_o     = cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: per-scenario tasks with inline checks plus a
// redirect scoreboard popped whenever the DUT accepts a redirect.
module tb_pipe_ctrl_n;
  localparam int N  = 6;
  localparam int AW = 32;
  localparam int CW = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_n_if #(.NUM_STAGES(N), .ADDR_W(AW), .CNT_W(CW)) bus ();

  pipe_ctrl_n #(
    .NUM_STAGES(N), .ADDR_W(AW), .BR_STAGE(3), .TRAP_STAGE(4),
    .BR_MASK(6'b001100), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [AW-1:0] sb_q[$];

  // {stalled, flush, branch_flag, branch_addr, redirect_pending}
  logic [45:0] obs;
  assign obs = {bus.stalled_o, bus.flush_o, bus.branch_flag_o, bus.branch_addr_o,
                bus.redirect_pending_o};

  task automatic idle();
    bus.stallreq_i    = '0;
    bus.branch_flag_i = 1'b0;
    bus.branch_addr_i = '0;
    bus.trap_flag_i   = 1'b0;
    bus.trap_addr_i   = '0;
    bus.fetch_ready_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.stallreq_i    = '1;
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h80;
    bus.trap_flag_i   = 1'b1;
    bus.trap_addr_i   = 32'h90;
    bus.fetch_ready_i = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({obs, bus.stall_cycles_o, bus.stall_timeout_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%0d/%b expected all zero", obs, bus.stall_cycles_o,
               bus.stall_timeout_o);
    end
    idle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h expected 0", obs);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    bus.stallreq_i = 6'b010000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== {6'b011111, 6'b0, 1'b0, 32'h0, 1'b0} || bus.stall_cycles_o !== CW'(c)) begin
        n_fail++;
        $display("FAIL stall_vec c=%0d: got %h cnt %0d expected %h cnt %0d", c, obs,
                 bus.stall_cycles_o, {6'b011111, 40'h0}, c);
      end
      next_cycle();
    end
    idle();
    next_cycle();
    @(negedge clk);
    n_chk++;
    if (bus.stall_cycles_o !== '0 || obs !== '0) begin
      n_fail++;
      $display("FAIL stall_clear: got cnt %0d obs %h expected 0", bus.stall_cycles_o, obs);
    end
    next_cycle();
  endtask

  task automatic test_watchdog();
    bus.stallreq_i = 6'b000100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++;
      if (bus.stalled_o !== 6'b000111 || bus.stall_cycles_o !== CW'(c) ||
          bus.stall_timeout_o !== (c == TO)) begin
        n_fail++;
        $display("FAIL watchdog c=%0d: got stalled %b cnt %0d to %b expected 000111 %0d %b", c,
                 bus.stalled_o, bus.stall_cycles_o, bus.stall_timeout_o, c, (c == TO));
      end
      next_cycle();
    end
    idle();
    next_cycle();
    @(negedge clk);
    n_chk++;
    if (bus.stall_cycles_o !== '0 || bus.stall_timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL watchdog_clear: got cnt %0d to %b expected 0 0", bus.stall_cycles_o,
               bus.stall_timeout_o);
    end
    next_cycle();
  endtask

  task automatic test_saturate();
    int pulses;
    pulses = 0;
    bus.stallreq_i = 6'b100000;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (bus.stall_timeout_o === 1'b1) pulses++;
      next_cycle();
    end
    @(negedge clk);
    n_chk++;
    if (bus.stall_cycles_o !== 8'hFF) begin
      n_fail++;
      $display("FAIL cnt_saturate: got %0d expected 255", bus.stall_cycles_o);
    end
    n_chk++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL timeout_once: got %0d pulses expected 1", pulses);
    end
    idle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_branch_accept();
    bus.stallreq_i    = 6'b001000;
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h80;
    bus.fetch_ready_i = 1'b1;
    sb_q.push_back(32'h80);
    @(negedge clk);
    n_chk++;
    if (obs !== {6'b000000, 6'b000110, 1'b1, 32'h80, 1'b0}) begin
      n_fail++;
      $display("FAIL branch_accept: got %h expected %h", obs,
               {6'b000000, 6'b000110, 1'b1, 32'h80, 1'b0});
    end
    next_cycle();
    bus.stallreq_i    = 6'b010100;
    bus.branch_addr_i = 32'hC0;
    sb_q.push_back(32'hC0);
    @(negedge clk);
    n_chk++;
    if (obs !== {6'b011111, 6'b000110, 1'b1, 32'hC0, 1'b0}) begin
      n_fail++;
      $display("FAIL branch_mask_partial: got %h expected %h", obs,
               {6'b011111, 6'b000110, 1'b1, 32'hC0, 1'b0});
    end
    idle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_pending();
    logic [45:0] exp [4];
    exp[0] = {6'b000000, 6'b000000, 1'b0, 32'h100, 1'b0};
    exp[1] = {6'b000001, 6'b000010, 1'b0, 32'h100, 1'b1};
    exp[2] = {6'b000001, 6'b000010, 1'b0, 32'h100, 1'b1};
    exp[3] = {6'b000001, 6'b000110, 1'b1, 32'h100, 1'b1};
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h100;
    sb_q.push_back(32'h100);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) bus.branch_flag_i = 1'b0;
      if (c == 3) bus.fetch_ready_i = 1'b1;
      @(negedge clk);
      n_chk++;
      if (obs !== exp[c]) begin
        n_fail++;
        $display("FAIL pending c=%0d: got %h expected %h", c + 1, obs, exp[c]);
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL pending_done: got %h expected 0", obs);
    end
    next_cycle();
  endtask

  task automatic test_trap_priority();
    bus.trap_flag_i   = 1'b1;
    bus.trap_addr_i   = 32'h200;
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h300;
    bus.fetch_ready_i = 1'b1;
    sb_q.push_back(32'h200);
    @(negedge clk);
    n_chk++;
    if (obs !== {6'b000000, 6'b001110, 1'b1, 32'h200, 1'b0}) begin
      n_fail++;
      $display("FAIL trap_wins: got %h expected %h", obs,
               {6'b000000, 6'b001110, 1'b1, 32'h200, 1'b0});
    end
    next_cycle();
    idle();
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h300;
    next_cycle();
    idle();
    bus.trap_flag_i = 1'b1;
    bus.trap_addr_i = 32'h400;
    sb_q.push_back(32'h400);
    @(negedge clk);
    n_chk++;
    if (obs !== {6'b000001, 6'b000010, 1'b0, 32'h400, 1'b1}) begin
      n_fail++;
      $display("FAIL trap_overwrite: got %h expected %h", obs,
               {6'b000001, 6'b000010, 1'b0, 32'h400, 1'b1});
    end
    next_cycle();
    idle();
    bus.fetch_ready_i = 1'b1;
    @(negedge clk);
    n_chk++;
    if (obs !== {6'b000001, 6'b001110, 1'b1, 32'h400, 1'b1}) begin
      n_fail++;
      $display("FAIL trap_issue: got %h expected %h", obs,
               {6'b000001, 6'b001110, 1'b1, 32'h400, 1'b1});
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_reset_pending();
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h500;
    next_cycle();
    idle();
    @(negedge clk);
    n_chk++;
    if (obs !== {6'b000001, 6'b000010, 1'b0, 32'h500, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_pend_setup: got %h expected %h", obs,
               {6'b000001, 6'b000010, 1'b0, 32'h500, 1'b1});
    end
    next_cycle();
    rst = 1'b0;
    #1;
    n_chk++;
    if ({obs, bus.stall_cycles_o, bus.stall_timeout_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_pending: got %h cnt %0d expected all zero", obs,
               bus.stall_cycles_o);
    end
    bus.fetch_ready_i = 1'b1;
    next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL rst_no_redirect c=%0d: got %h expected 0", c, obs);
      end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    fork
      forever begin
        @(negedge clk);
        if (bus.branch_flag_o === 1'b1) begin
          n_chk++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got redirect to %h expected none", bus.branch_addr_o);
          end else begin
            logic [AW-1:0] e;
            e = sb_q.pop_front();
            if (bus.branch_addr_o !== e) begin
              n_fail++;
              $display("FAIL sb_addr: got %h expected %h", bus.branch_addr_o, e);
            end
          end
        end
      end
    join_none
    test_reset();
    test_stall();
    test_watchdog();
    test_saturate();
    test_branch_accept();
    test_pending();
    test_trap_priority();
    test_reset_pending();
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d outstanding expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
